// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory stage: RV32I load/store funct3
// codes and the access state machine encoding.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory: builds the store byte enables and
// replicated store word, extracts and extends the load result, and flags
// accesses whose address is not a multiple of the access size.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_low,
    input  logic [31:0] write_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic        is_byte;
    logic        is_half;
    logic        is_signed;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Decode the access size; BU/HU only exist for loads, so a store with
    // those codes falls through to a full word like any other unknown code.
    always_comb begin
        is_byte   = (funct3 == F3_B) || (!write && funct3 == F3_BU);
        is_half   = (funct3 == F3_H) || (!write && funct3 == F3_HU);
        is_signed = (funct3 == F3_B) || (funct3 == F3_H);
        byte_val  = read_word[{addr_low, 3'b000} +: 8];
        half_val  = addr_low[1] ? read_word[31:16] : read_word[15:0];
    end

    // Lane selection and extension; words ignore the low address bits.
    always_comb begin
        byte_en    = 4'b1111;
        store_word = write_data;
        load_data  = read_word;
        misaligned = |addr_low;
        if (is_byte) begin
            byte_en    = 4'b0001 << addr_low;
            store_word = {4{write_data[7:0]}};
            load_data  = {{24{is_signed & byte_val[7]}}, byte_val};
            misaligned = 1'b0;
        end else if (is_half) begin
            byte_en    = addr_low[1] ? 4'b1100 : 4'b0011;
            store_word = {2{write_data[15:0]}};
            load_data  = {{16{is_signed & half_val[15]}}, half_val};
            misaligned = addr_low[0];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32I data-memory stage with a word-organised internal RAM and a
// request/ready handshake that inserts WAIT_CYCLES wait states.
// Optional feature: define MISALIGN_CHECK_EN to fault misaligned halves/words
// instead of silently forcing them to natural alignment.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReq,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  MemReady,
    output logic                  MemBusy,
    output logic                  MemFault
);

    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    mem_state_t state, next_state;
    logic [CW-1:0] count, next_count;
    logic enter_done;

    logic                  write_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  op_write;
    logic [2:0]            op_funct3;
    logic [ADDR_WIDTH+1:0] op_addr;
    logic [DATA_WIDTH-1:0] op_data;

    logic [DATA_WIDTH-1:0] ram [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] read_word;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] store_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  lane_misaligned;
    logic                  access_fault;
    logic                  fault_q;
    logic                  addr_unused;

    assign addr_unused = ^ALUResult[DATA_WIDTH-1:ADDR_WIDTH+2];

    // With zero wait states the access happens on the accepting edge, so the
    // live inputs are used while idle and the latched copy afterwards.
    always_comb begin
        op_write  = write_q;
        op_funct3 = funct3_q;
        op_addr   = addr_q;
        op_data   = data_q;
        if (state == IDLE) begin
            op_write  = MemWrite;
            op_funct3 = Funct3;
            op_addr   = ALUResult[ADDR_WIDTH+1:0];
            op_data   = WriteData;
        end
    end

    assign read_word = ram[op_addr[ADDR_WIDTH+1:2]];

    mem_lane_align u_align (
        .write      (op_write),
        .funct3     (op_funct3),
        .addr_low   (op_addr[1:0]),
        .write_data (op_data),
        .read_word  (read_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data),
        .misaligned (lane_misaligned)
    );

`ifdef MISALIGN_CHECK_EN
    assign access_fault = lane_misaligned;
`else
    logic misalign_unused;
    assign misalign_unused = lane_misaligned;
    assign access_fault    = 1'b0;
`endif

    // Next-state logic; enter_done marks the edge that performs the access.
    always_comb begin
        next_state = state;
        next_count = count;
        enter_done = 1'b0;
        case (state)
            IDLE: begin
                if (MemReq) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = DONE;
                        enter_done = 1'b1;
                    end else begin
                        next_state = WAIT;
                        next_count = CW'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (count == CW'(1)) begin
                    next_state = DONE;
                    next_count = '0;
                    enter_done = 1'b1;
                end else begin
                    next_count = count - CW'(1);
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Capture the request operands when a new access is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (state == IDLE && MemReq) begin
            write_q  <= MemWrite;
            funct3_q <= Funct3;
            addr_q   <= ALUResult[ADDR_WIDTH+1:0];
            data_q   <= WriteData;
        end
    end

    // Load result and fault flag are registered on the access edge; stores keep ReadData.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadData <= '0;
            fault_q  <= 1'b0;
        end else if (enter_done) begin
            fault_q <= access_fault;
            if (!op_write) begin
                ReadData <= access_fault ? '0 : load_data;
            end
        end
    end

    // RAM byte-lane writes; never reset, and blocked while reset is held.
    always_ff @(posedge clk) begin
        if (enter_done && op_write && !access_fault && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram[op_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    assign MemReady = (state == DONE);
    assign MemBusy  = (state != IDLE);
    assign MemFault = (state == DONE) && fault_q;

endmodule
